// File: rtl/alien_pkg.sv
// Shared types and constants for the alien free-direction evaluator.
// Build option: ALIEN_FREE_DIR_TIMEOUT_EN enables the map-read watchdog.
package alien_pkg;

  localparam logic [10:0] BOARD_X = 11'd32;
  localparam logic [10:0] BOARD_Y = 11'd160;
  localparam int unsigned TILE_LOG2 = 5;
  localparam int unsigned COLS = 18;
  localparam int unsigned ROWS = 10;
  // Width of a tile coordinate derived from an 11-bit pixel offset.
  localparam int unsigned TILE_W = 11 - TILE_LOG2;

  // Bit positions inside the free-direction code.
  localparam int unsigned DIR_LEFT   = 3;
  localparam int unsigned DIR_TOP    = 2;
  localparam int unsigned DIR_RIGHT  = 1;
  localparam int unsigned DIR_BOTTOM = 0;

  localparam logic [3:0] FREE_HORIZ = 4'b1010;
  localparam logic [3:0] FREE_VERT  = 4'b0101;

  typedef enum logic [1:0] {StIdle, StLocate, StProbe, StDone} state_e;

  typedef struct packed {
    logic       ok;
    logic [4:0] col;
    logic [3:0] row;
  } tile_ref_t;

  // Probe order index (0 left, 1 top, 2 right, 3 bottom) to result bit.
  function automatic logic [1:0] dir_bit(input logic [1:0] idx);
    case (idx)
      2'd0:    dir_bit = 2'(DIR_LEFT);
      2'd1:    dir_bit = 2'(DIR_TOP);
      2'd2:    dir_bit = 2'(DIR_RIGHT);
      default: dir_bit = 2'(DIR_BOTTOM);
    endcase
  endfunction

  // Neighbour tile of (col,row) in probe direction idx, with an on-board flag.
  function automatic tile_ref_t neighbour(input logic [1:0]        idx,
                                          input logic [TILE_W-1:0] col,
                                          input logic [TILE_W-1:0] row);
    logic [TILE_W:0] nc;
    logic [TILE_W:0] nr;
    logic            ok;
    tile_ref_t       t;
    nc = {1'b0, col};
    nr = {1'b0, row};
    ok = 1'b1;
    case (idx)
      2'd0: begin
        ok = (col != '0);
        nc = nc - {{TILE_W{1'b0}}, 1'b1};
      end
      2'd1: begin
        ok = (row != '0);
        nr = nr - {{TILE_W{1'b0}}, 1'b1};
      end
      2'd2:    nc = nc + {{TILE_W{1'b0}}, 1'b1};
      default: nr = nr + {{TILE_W{1'b0}}, 1'b1};
    endcase
    t.ok  = ok && (nc < (TILE_W + 1)'(COLS)) && (nr < (TILE_W + 1)'(ROWS));
    t.col = nc[4:0];
    t.row = nr[3:0];
    return t;
  endfunction

endpackage

// File: rtl/alien_free_dir_if.sv
// Request/acknowledge read port into the dug-tunnel map.
interface alien_free_dir_if;
  logic       map_rd_req;
  logic [4:0] map_rd_col;
  logic [3:0] map_rd_row;
  logic       map_rd_ack;
  logic       map_rd_dug;

  modport master (
    output map_rd_req, map_rd_col, map_rd_row,
    input  map_rd_ack, map_rd_dug
  );

  modport slave (
    input  map_rd_req, map_rd_col, map_rd_row,
    output map_rd_ack, map_rd_dug
  );
endinterface

// File: rtl/tile_locator.sv
// Combinational pixel-to-tile conversion for the alien's top-left corner.
module tile_locator
  import alien_pkg::*;
(
  input  logic [10:0]       x_i,
  input  logic [10:0]       y_i,
  output logic [TILE_W-1:0] col_o,
  output logic [TILE_W-1:0] row_o,
  output logic              aligned_x_o,
  output logic              aligned_y_o,
  output logic              off_board_o
);

  logic [10:0] rel_x;
  logic [10:0] rel_y;

  // Board-relative offsets split into tile index and in-tile remainder.
  always_comb begin
    rel_x       = x_i - BOARD_X;
    rel_y       = y_i - BOARD_Y;
    col_o       = rel_x[10:TILE_LOG2];
    row_o       = rel_y[10:TILE_LOG2];
    aligned_x_o = (rel_x[TILE_LOG2-1:0] == '0);
    aligned_y_o = (rel_y[TILE_LOG2-1:0] == '0);
    off_board_o = (x_i < BOARD_X) || (y_i < BOARD_Y);
  end

endmodule

// File: rtl/alien_free_dir.sv
// Per-frame free-direction evaluator: locates the alien's tile, probes the four
// neighbours in the tunnel map and publishes which moves stay inside dug tunnel.
// Build option: ALIEN_FREE_DIR_TIMEOUT_EN adds a 63-cycle watchdog per map read.
module alien_free_dir
  import alien_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [10:0]             alien_top_leftX,
  input  logic [10:0]             alien_top_leftY,
  alien_free_dir_if.master        map_if,
  output logic [3:0]              free_direction,
  output logic                    free_valid
);

  state_e            state_q, state_d;
  logic [10:0]       x_q, x_d;
  logic [10:0]       y_q, y_d;
  logic [TILE_W-1:0] col_q, col_d;
  logic [TILE_W-1:0] row_q, row_d;
  logic [1:0]        dir_q, dir_d;
  logic [3:0]        acc_q, acc_d;
  logic [3:0]        fd_q, fd_d;
  logic              fv_q, fv_d;
  logic              req_q, req_d;
  logic [4:0]        rcol_q, rcol_d;
  logic [3:0]        rrow_q, rrow_d;
`ifdef ALIEN_FREE_DIR_TIMEOUT_EN
  logic [5:0]        timer_q, timer_d;
`endif

  logic [TILE_W-1:0] loc_col;
  logic [TILE_W-1:0] loc_row;
  logic              loc_ax;
  logic              loc_ay;
  logic              loc_off;
  tile_ref_t         nb_first;
  tile_ref_t         nb_cur;
  tile_ref_t         nb_next;
  logic              advance;
  logic              preissue;

  tile_locator u_tile_locator (
    .x_i        (x_q),
    .y_i        (y_q),
    .col_o      (loc_col),
    .row_o      (loc_row),
    .aligned_x_o(loc_ax),
    .aligned_y_o(loc_ay),
    .off_board_o(loc_off)
  );

  // Next-state logic. A request is pre-issued on entry to a probe only when the
  // previous cycle carried no request, so back-to-back requests never change
  // address between consecutive cycles.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    row_d    = row_q;
    dir_d    = dir_q;
    acc_d    = acc_q;
    fd_d     = fd_q;
    fv_d     = 1'b0;
    req_d    = req_q;
    rcol_d   = rcol_q;
    rrow_d   = rrow_q;
    advance  = 1'b0;
    preissue = 1'b0;
    nb_first = neighbour(2'd0, loc_col, loc_row);
    nb_cur   = neighbour(dir_q, col_q, row_q);
    nb_next  = neighbour(dir_q + 2'd1, col_q, row_q);
`ifdef ALIEN_FREE_DIR_TIMEOUT_EN
    timer_d  = req_q ? timer_q + 6'd1 : '0;
`endif
    case (state_q)
      StIdle: begin
        if (startOfFrame) begin
          x_d     = alien_top_leftX;
          y_d     = alien_top_leftY;
          state_d = StLocate;
        end
      end
      StLocate: begin
        col_d   = loc_col;
        row_d   = loc_row;
        dir_d   = 2'd0;
        acc_d   = '0;
        state_d = StDone;
        if (loc_off) begin
          acc_d = fd_q;
        end else if (loc_ax && loc_ay) begin
          state_d = StProbe;
          if (nb_first.ok) begin
            req_d  = 1'b1;
            rcol_d = nb_first.col;
            rrow_d = nb_first.row;
          end
        end else if (loc_ay) begin
          acc_d = FREE_HORIZ;
        end else if (loc_ax) begin
          acc_d = FREE_VERT;
        end else begin
          acc_d = fd_q;
        end
      end
      StProbe: begin
        if (req_q) begin
          if (map_if.map_rd_ack) begin
            acc_d[dir_bit(dir_q)] = map_if.map_rd_dug;
            req_d   = 1'b0;
            advance = 1'b1;
          end
`ifdef ALIEN_FREE_DIR_TIMEOUT_EN
          else if (timer_q == 6'd62) begin
            acc_d[dir_bit(dir_q)] = 1'b0;
            req_d   = 1'b0;
            advance = 1'b1;
          end
`endif
        end else if (!nb_cur.ok) begin
          acc_d[dir_bit(dir_q)] = 1'b0;
          advance  = 1'b1;
          preissue = 1'b1;
        end else begin
          req_d  = 1'b1;
          rcol_d = nb_cur.col;
          rrow_d = nb_cur.row;
        end
        if (advance) begin
          if (dir_q == 2'd3) begin
            state_d = StDone;
          end else begin
            dir_d = dir_q + 2'd1;
            if (preissue && nb_next.ok) begin
              req_d  = 1'b1;
              rcol_d = nb_next.col;
              rrow_d = nb_next.row;
            end
          end
        end
      end
      StDone: begin
        fd_d    = acc_q;
        fv_d    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset drops any outstanding read at once.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dir_q   <= '0;
      acc_q   <= '0;
      fd_q    <= '0;
      fv_q    <= 1'b0;
      req_q   <= 1'b0;
      rcol_q  <= '0;
      rrow_q  <= '0;
`ifdef ALIEN_FREE_DIR_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dir_q   <= dir_d;
      acc_q   <= acc_d;
      fd_q    <= fd_d;
      fv_q    <= fv_d;
      req_q   <= req_d;
      rcol_q  <= rcol_d;
      rrow_q  <= rrow_d;
`ifdef ALIEN_FREE_DIR_TIMEOUT_EN
      timer_q <= timer_d;
`endif
    end
  end

  assign map_if.map_rd_req = req_q;
  assign map_if.map_rd_col = rcol_q;
  assign map_if.map_rd_row = rrow_q;
  assign free_direction    = fd_q;
  assign free_valid        = fv_q;

endmodule

// File: tb/tb_alien_free_dir.sv
// Bench for alien_free_dir: table vectors, randomized positions/maps against a
// tile-arithmetic reference model, and hand sequences for reset and timeout.
module tb_alien_free_dir;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sof;
  logic [10:0] ax;
  logic [10:0] ay;
  logic [3:0]  fd;
  logic        fv;

  always #5 clk = ~clk;

  alien_free_dir_if bus ();

  alien_free_dir dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .alien_top_leftX(ax),
    .alien_top_leftY(ay),
    .map_if         (bus),
    .free_direction (fd),
    .free_valid     (fv)
  );

  int   tests = 0;
  int   fails = 0;
  logic dug_map [0:17][0:9];
  int   ack_delay = 0;
  int   hold_col = -1;
  int   hold_row = -1;
  int   req_log[$];
  int   exp_req[$];
  int   addr_err = 0;
  int   run_len = 0;
  int   max_run = 0;
  int   valid_cnt = 0;
  int   cnt = 0;
  logic prev_req = 1'b0;
  int   prev_addr = 0;
  int   cur_a;
  logic [3:0] model_prev = 4'b0000;

  function automatic logic map_at(input int c, input int r);
    if (c >= 0 && c < 18 && r >= 0 && r < 10) return dug_map[c][r];
    return 1'b0;
  endfunction

  // Map responder: acks after ack_delay extra cycles, logs each new request.
  always @(negedge clk) begin
    if (fv) valid_cnt++;
    if (!resetN || !bus.map_rd_req) begin
      cnt = 0;
      bus.map_rd_ack = 1'b0;
      bus.map_rd_dug = 1'b0;
      if (run_len > max_run) max_run = run_len;
      run_len = 0;
      prev_req = 1'b0;
    end else begin
      cur_a = int'(bus.map_rd_col) * 16 + int'(bus.map_rd_row);
      if (prev_req && cur_a != prev_addr) addr_err++;
      if (cnt == 0) req_log.push_back(cur_a);
      run_len++;
      if (!(int'(bus.map_rd_col) == hold_col && int'(bus.map_rd_row) == hold_row) &&
          cnt >= ack_delay) begin
        bus.map_rd_ack = 1'b1;
        bus.map_rd_dug = map_at(int'(bus.map_rd_col), int'(bus.map_rd_row));
        cnt = 0;
      end else begin
        bus.map_rd_ack = 1'b0;
        cnt++;
      end
      prev_req = 1'b1;
      prev_addr = cur_a;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_map();
    for (int c = 0; c < 18; c++)
      for (int r = 0; r < 10; r++) dug_map[c][r] = 1'b0;
  endtask

  task automatic set_tile(input int c, input int r, input int v);
    if (c >= 0 && c < 18 && r >= 0 && r < 10) dug_map[c][r] = (v != 0);
  endtask

  task automatic set_neigh(input int x, input int y, input int l, input int t,
                           input int rt, input int b);
    int c, r;
    c = (x - 32) / 32;
    r = (y - 160) / 32;
    set_tile(c - 1, r, l);
    set_tile(c, r - 1, t);
    set_tile(c + 1, r, rt);
    set_tile(c, r + 1, b);
  endtask

  // Reference: tile arithmetic straight from the board geometry.
  task automatic model(input int x, input int y, input logic [3:0] prev,
                       output logic [3:0] efd);
    int rx, ry, c, r, nc, nr;
    int dc[4];
    int dr[4];
    dc = '{-1, 0, 1, 0};
    dr = '{0, -1, 0, 1};
    exp_req.delete();
    efd = prev;
    if (x >= 32 && y >= 160) begin
      rx = x - 32;
      ry = y - 160;
      if (rx % 32 == 0 && ry % 32 == 0) begin
        c = rx / 32;
        r = ry / 32;
        efd = 4'b0000;
        for (int k = 0; k < 4; k++) begin
          nc = c + dc[k];
          nr = r + dr[k];
          if (nc >= 0 && nc < 18 && nr >= 0 && nr < 10) begin
            exp_req.push_back(nc * 16 + nr);
            efd[3-k] = map_at(nc, nr);
          end
        end
      end else if (ry % 32 == 0) begin
        efd = 4'b1010;
      end else if (rx % 32 == 0) begin
        efd = 4'b0101;
      end
    end
  endtask

  task automatic run_eval(input int x, input int y, input int delay, input int resof_at,
                          output logic [3:0] got, output int lat);
    logic [3:0] efd;
    logic [3:0] fd_before;
    logic       held;
    int         n, v0, mism;
    model(x, y, model_prev, efd);
    ack_delay = delay;
    @(posedge clk);
    #1;
    req_log.delete();
    max_run = 0;
    v0 = valid_cnt;
    fd_before = fd;
    held = 1'b1;
    sof = 1'b1;
    ax = 11'(x);
    ay = 11'(y);
    @(posedge clk);
    #1;
    sof = 1'b0;
    n = 1;
    while (!fv && n < 600) begin
      if (fd !== fd_before) held = 1'b0;
      if (n == resof_at) begin
        sof = 1'b1;
        ax = 11'(x + 7);
      end else begin
        sof = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    sof = 1'b0;
    lat = n;
    got = fd;
    chk("valid_seen", int'(fv), 1);
    chk("fd_model", int'(fd), int'(efd));
    chk("fd_held", int'(held), 1);
    chk("req_count", req_log.size(), exp_req.size());
    mism = 0;
    for (int i = 0; i < req_log.size() && i < exp_req.size(); i++)
      if (req_log[i] != exp_req[i]) mism++;
    chk("req_addrs", mism, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("valid_once", valid_cnt - v0, 1);
    model_prev = efd;
  endtask

  typedef struct {
    int         x;
    int         y;
    int         dl, dt, dr, db;
    int         delay;
    int         resof;
    logic [3:0] exp_fd;
    int         exp_lat;
    int         exp_nreq;
  } vec_t;

  vec_t       vecs[12];
  logic [3:0] got;
  int         lat;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{448, 160, 1, 0, 0, 1, 2, 0, 4'b1001, 0, 3};
    vecs[1]  = '{460, 192, 0, 0, 0, 0, 0, 0, 4'b1010, 3, 0};
    vecs[2]  = '{32,  448, 0, 1, 1, 0, 0, 0, 4'b0110, 0, 2};
    vecs[3]  = '{576, 160, 1, 0, 0, 1, 0, 0, 4'b1001, 7, 2};
    vecs[4]  = '{20,  200, 1, 1, 1, 1, 0, 0, 4'b1001, 3, 0};
    vecs[5]  = '{64,  170, 0, 0, 0, 0, 0, 0, 4'b0101, 3, 0};
    vecs[6]  = '{70,  170, 0, 0, 0, 0, 0, 0, 4'b0101, 3, 0};
    vecs[7]  = '{192, 256, 1, 1, 1, 1, 0, 0, 4'b1111, 0, 4};
    vecs[8]  = '{192, 256, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 4};
    vecs[9]  = '{64,  100, 1, 1, 1, 1, 0, 0, 4'b0000, 3, 0};
    vecs[10] = '{448, 160, 1, 0, 1, 1, 4, 3, 4'b1011, 0, 3};
    vecs[11] = '{608, 160, 1, 1, 1, 1, 0, 0, 4'b1000, 0, 1};

    resetN = 1'b0;
    sof = 1'b0;
    ax = '0;
    ay = '0;
    clear_map();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", int'(bus.map_rd_req), 0);
    chk("rst_col", int'(bus.map_rd_col), 0);
    chk("rst_row", int'(bus.map_rd_row), 0);
    chk("rst_fd", int'(fd), 0);
    chk("rst_valid", int'(fv), 0);
    resetN = 1'b1;

    for (int i = 0; i < 12; i++) begin
      clear_map();
      set_neigh(vecs[i].x, vecs[i].y, vecs[i].dl, vecs[i].dt, vecs[i].dr, vecs[i].db);
      run_eval(vecs[i].x, vecs[i].y, vecs[i].delay, vecs[i].resof, got, lat);
      chk("tbl_fd", int'(got), int'(vecs[i].exp_fd));
      chk("tbl_nreq", req_log.size(), vecs[i].exp_nreq);
      if (vecs[i].exp_lat != 0) chk("tbl_latency", lat, vecs[i].exp_lat);
    end

    for (int it = 0; it < 40; it++) begin
      int mode, x, y;
      for (int c = 0; c < 18; c++)
        for (int r = 0; r < 10; r++) dug_map[c][r] = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
        x = 32 + 32 * $urandom_range(0, 17);
        y = 160 + 32 * $urandom_range(0, 9);
      end else if (mode == 6) begin
        x = 32 + 32 * $urandom_range(0, 25);
        y = 160 + 32 * $urandom_range(0, 13);
      end else if (mode == 7) begin
        x = 32 + 32 * $urandom_range(0, 17);
        y = 161 + $urandom_range(0, 300);
      end else if (mode == 8) begin
        x = 33 + $urandom_range(0, 500);
        y = 160 + 32 * $urandom_range(0, 9);
      end else begin
        x = $urandom_range(0, 1000);
        y = $urandom_range(0, 1000);
      end
      run_eval(x, y, $urandom_range(0, 3), 0, got, lat);
    end

    // Reset while a request is outstanding.
    run_eval(460, 192, 0, 0, got, lat);
    clear_map();
    set_neigh(448, 160, 1, 0, 1, 1);
    ack_delay = 6;
    @(posedge clk);
    #1;
    sof = 1'b1;
    ax = 11'd448;
    ay = 11'd160;
    @(posedge clk);
    #1;
    sof = 1'b0;
    for (int n = 0; n < 20 && !bus.map_rd_req; n++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_req_seen", int'(bus.map_rd_req), 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("rst_mid_req", int'(bus.map_rd_req), 0);
    chk("rst_mid_fd", int'(fd), 0);
    chk("rst_mid_valid", int'(fv), 0);
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
    model_prev = 4'b0000;
    clear_map();
    set_neigh(448, 160, 1, 0, 0, 1);
    run_eval(448, 160, 1, 0, got, lat);
    chk("rst_restart_fd", int'(got), 4'b1001);

`ifdef ALIEN_FREE_DIR_TIMEOUT_EN
    // Right probe never acknowledged: watchdog drops it and bottom proceeds.
    clear_map();
    set_neigh(448, 160, 1, 0, 0, 1);
    hold_col = 14;
    hold_row = 0;
    run_eval(448, 160, 0, 0, got, lat);
    chk("timeout_fd", int'(got), 4'b1001);
    chk("timeout_len", max_run, 63);
    hold_col = -1;
    hold_row = -1;
`endif

    chk("addr_stable", addr_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
